// File: rtl/playfield_ram.sv
// Tetris board store: ROWS x COLS grid of block-type codes with a combinational render read
// port, a single-cell write port and a line-clear sequencer that collapses full rows.
module playfield_ram #(
    parameter int ROWS   = 12,
    parameter int COLS   = 21,
    parameter int TYPE_W = 3
) (
    input  logic              clk_25_175,
    input  logic              reset,
    input  logic [4:0]        rd_row,
    input  logic [4:0]        rd_col,
    output logic [TYPE_W-1:0] rd_type,
    input  logic              wr_en,
    input  logic [4:0]        wr_row,
    input  logic [4:0]        wr_col,
    input  logic [TYPE_W-1:0] wr_type,
    input  logic              clr_all,
    input  logic              clear_req,
    output logic              busy,
    output logic              done,
    output logic [4:0]        lines_cleared
);

    // Handshake: clear_req is a one-cycle start pulse honoured only while busy=0; busy stays
    // high from the cycle after the request through the single-cycle done pulse.
    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
    localparam logic [4:0] ROW_LIMIT = 5'(ROWS);
    localparam logic [4:0] COL_LIMIT = 5'(COLS);

    state_t state;
    logic [4:0] r;
    logic [4:0] k;
    logic [ROWS-1:0][COLS-1:0][TYPE_W-1:0] cells;
    logic row_full;
    logic wr_ok;

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign wr_ok = wr_en && (wr_row < ROW_LIMIT) && (wr_col < COL_LIMIT);

    // Out-of-range coordinates match no cell, so the read falls through to 0.
    always_comb begin
        rd_type = '0;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                if ((5'(i) == rd_row) && (5'(j) == rd_col)) begin
                    rd_type = cells[i][j];
                end
            end
        end
    end

    always_comb begin
        row_full = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            if (5'(i) == r) begin
                row_full = 1'b1;
                for (int j = 0; j < COLS; j++) begin
                    if (cells[i][j] == '0) begin
                        row_full = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_25_175 or posedge reset) begin
        if (reset) begin
            cells         <= '0;
            state         <= IDLE;
            r             <= 5'd0;
            k             <= 5'd0;
            lines_cleared <= 5'd0;
        end else if (clr_all) begin
            cells <= '0;
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_ok) begin
                        for (int i = 0; i < ROWS; i++) begin
                            for (int j = 0; j < COLS; j++) begin
                                if ((5'(i) == wr_row) && (5'(j) == wr_col)) begin
                                    cells[i][j] <= wr_type;
                                end
                            end
                        end
                    end
                    if (clear_req) begin
                        r             <= LAST_ROW;
                        lines_cleared <= 5'd0;
                        state         <= SCAN;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        if (lines_cleared < ROW_LIMIT) begin
                            lines_cleared <= lines_cleared + 5'd1;
                        end
                        k     <= r;
                        state <= SHIFT;
                    end else if (r != 5'd0) begin
                        r <= r - 5'd1;
                    end else begin
                        state <= DONE;
                    end
                end
                SHIFT: begin
                    // Pull one row down per cycle from k toward the top; r is kept so the
                    // row that dropped into place is scanned again.
                    for (int i = 1; i < ROWS; i++) begin
                        if (5'(i) == k) begin
                            cells[i] <= cells[i-1];
                        end
                    end
                    if (k == 5'd0) begin
                        cells[0] <= '0;
                        state    <= SCAN;
                    end else begin
                        k <= k - 5'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_playfield_ram.sv
// Directed and randomized checks of playfield_ram against a row-list model of line clearing.
module tb_playfield_ram;

    localparam int ROWS   = 12;
    localparam int COLS   = 21;
    localparam int TYPE_W = 3;

    logic              clk_25_175;
    logic              reset;
    logic [4:0]        rd_row;
    logic [4:0]        rd_col;
    logic [TYPE_W-1:0] rd_type;
    logic              wr_en;
    logic [4:0]        wr_row;
    logic [4:0]        wr_col;
    logic [TYPE_W-1:0] wr_type;
    logic              clr_all;
    logic              clear_req;
    logic              busy;
    logic              done;
    logic [4:0]        lines_cleared;

    int checks = 0;
    int errors = 0;
    int model[ROWS][COLS];
    logic [4:0] exp_q[$];

    playfield_ram #(.ROWS(ROWS), .COLS(COLS), .TYPE_W(TYPE_W)) dut (
        .clk_25_175    (clk_25_175),
        .reset         (reset),
        .rd_row        (rd_row),
        .rd_col        (rd_col),
        .rd_type       (rd_type),
        .wr_en         (wr_en),
        .wr_row        (wr_row),
        .wr_col        (wr_col),
        .wr_type       (wr_type),
        .clr_all       (clr_all),
        .clear_req     (clear_req),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared)
    );

    // ---------------- clock ----------------
    initial clk_25_175 = 1'b0;
    always #20 clk_25_175 = ~clk_25_175;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_zero();
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                model[i][j] = 0;
    endfunction

    function automatic bit model_row_full(input int row);
        for (int j = 0; j < COLS; j++)
            if (model[row][j] == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Remove every full row, letting the rows above fall; a removal at row index r costs one
    // scan cycle plus r+1 shift cycles, every non-full row visit costs one scan cycle.
    function automatic void model_clear(output int lines, output int done_cyc);
        int row_q[$];
        int cost;
        int r;
        lines = 0;
        cost  = 0;
        r     = ROWS - 1;
        while (r >= 0) begin
            if (model_row_full(r)) begin
                lines++;
                cost += 2 + r;
                for (int i = r; i > 0; i--) row_q.push_back(i - 1);
                while (row_q.size() > 0) begin
                    int src;
                    src = row_q.pop_front();
                    for (int j = 0; j < COLS; j++) model[src + 1][j] = model[src][j];
                end
                for (int j = 0; j < COLS; j++) model[0][j] = 0;
            end else begin
                cost++;
                r--;
            end
        end
        if (lines > ROWS) lines = ROWS;
        done_cyc = cost + 1;
    endfunction

    // ---------------- drivers ----------------
    task automatic write_cell(input int row, input int col, input int typ);
        wr_en   = 1'b1;
        wr_row  = 5'(row);
        wr_col  = 5'(col);
        wr_type = TYPE_W'(typ);
        @(negedge clk_25_175);
        wr_en = 1'b0;
        if (row < ROWS && col < COLS) model[row][col] = typ;
    endtask

    task automatic wipe();
        clr_all = 1'b1;
        @(negedge clk_25_175);
        clr_all = 1'b0;
        model_zero();
    endtask

    task automatic fill_row(input int row, input int typ);
        for (int j = 0; j < COLS; j++)
            write_cell(row, j, (typ == 0) ? int'($urandom_range(1, 7)) : typ);
    endtask

    task automatic read_at(input string tag, input int row, input int col, input int exp);
        rd_row = 5'(row);
        rd_col = 5'(col);
        #1;
        check(tag, 32'(rd_type), 32'(exp));
    endtask

    task automatic check_board(input string tag);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                read_at($sformatf("%s[%0d][%0d]", tag, i, j), i, j, model[i][j]);
        for (int n = 0; n < 4; n++) begin
            read_at({tag, "_row_oor"}, int'($urandom_range(ROWS, 31)), int'($urandom_range(0, 31)), 0);
            read_at({tag, "_col_oor"}, int'($urandom_range(0, ROWS - 1)), int'($urandom_range(COLS, 31)), 0);
        end
        @(negedge clk_25_175);
    endtask

    // Issues clear_req in cycle 0 and expects done in the model's cycle; poke writes cell
    // (0,0) while busy, which must be dropped.
    task automatic run_clear(input string tag, input bit poke);
        int exp_lines;
        int exp_done;
        int cyc;
        int got;
        model_clear(exp_lines, exp_done);
        exp_q.push_back(5'(exp_lines));
        clear_req = 1'b1;
        @(negedge clk_25_175);
        clear_req = 1'b0;
        wr_en     = 1'b0;
        cyc = 1;
        got = -1;
        while (got < 0 && cyc <= 1000) begin
            if (cyc == 1) check({tag, "_busy_start"}, 32'(busy), 32'd1);
            if (poke && cyc == 3) begin
                wr_en = 1'b1; wr_row = 5'd0; wr_col = 5'd0; wr_type = 3'd7;
            end
            if (poke && cyc == 4) wr_en = 1'b0;
            if (done === 1'b1) begin
                got = cyc;
                check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
            end else begin
                @(negedge clk_25_175);
                cyc++;
            end
        end
        wr_en = 1'b0;
        check({tag, "_done_cycle"}, 32'(got), 32'(exp_done));
        @(negedge clk_25_175);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_lines"}, 32'(lines_cleared), 32'(exp_q.pop_front()));
        check_board(tag);
    endtask

    task automatic build_random();
        wipe();
        for (int r = 0; r < ROWS; r++) begin
            int mode;
            int hole;
            mode = int'($urandom_range(0, 3));
            hole = int'($urandom_range(0, COLS - 1));
            for (int j = 0; j < COLS; j++) begin
                if (mode == 0 || (mode == 1 && j != hole) || (mode == 2 && $urandom_range(0, 1) == 1))
                    write_cell(r, j, int'($urandom_range(1, 7)));
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seen_done;
        reset = 1'b1; clr_all = 1'b0; clear_req = 1'b0; wr_en = 1'b0;
        wr_row = '0; wr_col = '0; wr_type = '0; rd_row = '0; rd_col = '0;
        model_zero();
        #5;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_lines", 32'(lines_cleared), 32'd0);
        @(negedge clk_25_175);
        reset = 1'b0;
        check_board("reset_board");

        // write/read and dropped writes
        write_cell(3, 5, 6);
        read_at("wr_3_5", 3, 5, 6);
        write_cell(12, 0, 1);
        write_cell(0, 21, 1);
        write_cell(31, 31, 5);
        check_board("wr_oor");

        // no full rows, plus a write while busy
        write_cell(11, 0, 4);
        write_cell(0, 20, 2);
        run_clear("no_full", 1'b1);

        // single line
        wipe();
        fill_row(11, 2);
        write_cell(10, 4, 5);
        run_clear("single", 1'b0);
        read_at("single_11_4", 11, 4, 5);
        read_at("single_11_0", 11, 0, 0);

        // stacked lines
        wipe();
        fill_row(10, 0);
        fill_row(11, 0);
        write_cell(9, 0, 3);
        run_clear("stacked", 1'b0);
        read_at("stacked_11_0", 11, 0, 3);

        // every row full
        wipe();
        for (int r = 0; r < ROWS; r++) fill_row(r, 0);
        run_clear("all_full", 1'b0);

        // write and clear_req together
        wipe();
        for (int j = 0; j < COLS; j++) if (j != 7) write_cell(11, j, 2);
        wr_en = 1'b1; wr_row = 5'd11; wr_col = 5'd7; wr_type = 3'd4;
        model[11][7] = 4;
        run_clear("wr_and_req", 1'b0);

        // clr_all during SHIFT with a concurrent write and request
        wipe();
        fill_row(11, 0);
        clear_req = 1'b1;
        @(negedge clk_25_175);
        clear_req = 1'b0;
        @(negedge clk_25_175);
        clr_all = 1'b1; clear_req = 1'b1;
        wr_en = 1'b1; wr_row = 5'd1; wr_col = 5'd1; wr_type = 3'd5;
        @(negedge clk_25_175);
        clr_all = 1'b0; clear_req = 1'b0; wr_en = 1'b0;
        model_zero();
        check("clr_busy", 32'(busy), 32'd0);
        seen_done = 0;
        for (int n = 0; n < 20; n++) begin
            if (done === 1'b1) seen_done++;
            @(negedge clk_25_175);
        end
        check("clr_no_done", 32'(seen_done), 32'd0);
        check("clr_lines_held", 32'(lines_cleared), 32'd1);
        check_board("clr_board");

        // randomized boards
        for (int n = 0; n < 5; n++) begin
            build_random();
            run_clear($sformatf("rand%0d", n), n[0]);
        end

        // reset in the middle of a pass
        wipe();
        fill_row(11, 0);
        write_cell(2, 2, 6);
        clear_req = 1'b1;
        @(negedge clk_25_175);
        clear_req = 1'b0;
        @(negedge clk_25_175);
        @(negedge clk_25_175);
        #3 reset = 1'b1;
        #1;
        model_zero();
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_lines", 32'(lines_cleared), 32'd0);
        check_board("midreset_board");
        reset = 1'b0;
        write_cell(5, 9, 1);
        read_at("post_reset_wr", 5, 9, 1);
        @(negedge clk_25_175);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
